// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : serial_sub_pkg                                                 |
// | Brief   : Shared constants for the bit-serial subtractor: FSM state      |
// |           encodings and the default operand width.                       |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package serial_sub_pkg;

  // Default operand/result width in bits
  localparam int DEF_WIDTH = 8;

  // Controller states (2-bit legacy-compatible encoding)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage : serial_sub_pkg
`default_nettype wire

// File: rtl/serial_subtractor_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : serial_subtractor_if                                           |
// | Brief   : Operand/result handshake bundle for serial_subtractor.         |
// |           The master drives operands and accepts results; the slave is   |
// |           the subtractor. zero_out exists only when                      |
// |           SERIAL_SUB_ZERO_FLAG_EN is defined.                            |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] diff_out;
  logic             borrow_out;
  logic             done_valid;
  logic             done_ready;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
  logic             zero_out;

  modport master (
    output start_valid, a_in, b_in, done_ready,
    input  start_ready, diff_out, borrow_out, done_valid, zero_out
  );

  modport slave (
    input  start_valid, a_in, b_in, done_ready,
    output start_ready, diff_out, borrow_out, done_valid, zero_out
  );
`else
  modport master (
    output start_valid, a_in, b_in, done_ready,
    input  start_ready, diff_out, borrow_out, done_valid
  );

  modport slave (
    input  start_valid, a_in, b_in, done_ready,
    output start_ready, diff_out, borrow_out, done_valid
  );
`endif
endinterface : serial_subtractor_if
`default_nettype wire

// File: rtl/serial_subtractor_half_subtractor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : half_subtractor                                                |
// | Brief   : One-bit half subtractor: diff = a ^ b, borrow = ~a & b.        |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module half_subtractor (
  input  wire logic a,
  input  wire logic b,
  output logic      diff,
  output logic      borrow
);

  assign diff   = a ^ b;
  assign borrow = ~a & b;

endmodule : half_subtractor
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : serial_subtractor                                              |
// | Brief   : Bit-serial unsigned subtractor, DIFF = A - B, LSB first, one   |
// |           bit per clock, valid/ready on operand and result sides.        |
// |           Optional zero flag enabled by SERIAL_SUB_ZERO_FLAG_EN.         |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input wire logic          clk,
  input wire logic          rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  // Counter value during the final bit step of an operation
  localparam logic [CNT_W-1:0] C_LAST_STEP = CNT_W'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic [CNT_W-1:0] r_cnt;

  logic w_d0;
  logic w_b0;
  logic w_d;
  logic w_b1;
  logic w_br_next;
  logic w_last;

  // First cell subtracts the operand bits, second subtracts the running borrow
  half_subtractor u_hs_ab (
    .a      (r_a_sh[0]),
    .b      (r_b_sh[0]),
    .diff   (w_d0),
    .borrow (w_b0)
  );

  half_subtractor u_hs_br (
    .a      (w_d0),
    .b      (r_borrow),
    .diff   (w_d),
    .borrow (w_b1)
  );

  assign w_br_next = w_b0 | w_b1;
  assign w_last    = (r_cnt == C_LAST_STEP);

  // Controller and datapath: load on start handshake, shift one bit per RUN edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start_valid) begin
            r_a_sh   <= bus.a_in;
            r_b_sh   <= bus.b_in;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_diff   <= {w_d, r_diff[WIDTH-1:1]};
          r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_borrow <= w_br_next;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.done_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.start_ready = (r_state == ST_IDLE);
  assign bus.done_valid  = (r_state == ST_DONE);
  assign bus.diff_out    = r_diff;
  assign bus.borrow_out  = r_borrow;

`ifdef SERIAL_SUB_ZERO_FLAG_EN
  logic r_any_one;
  logic r_zero;

  // Track whether any result bit was 1; publish the inverted flag on the last step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_any_one <= 1'b0;
      r_zero    <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && bus.start_valid) begin
        r_any_one <= 1'b0;
        r_zero    <= 1'b0;
      end else if (r_state == ST_RUN) begin
        r_any_one <= r_any_one | w_d;
        if (w_last) begin
          r_zero <= ~(r_any_one | w_d);
        end
      end
    end
  end

  assign bus.zero_out = r_zero;
`endif

endmodule : serial_subtractor
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_serial_subtractor                                           |
// | Brief   : Directed self-checking bench for serial_subtractor (WIDTH=8).  |
// |           Zero-flag checks are active when SERIAL_SUB_ZERO_FLAG_EN is    |
// |           defined.                                                       |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  serial_subtractor_if #(.WIDTH(WIDTH)) sif ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Handshake, wait out the WIDTH bit steps, check result, then accept it
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_d, input logic exp_br, input logic exp_z);
    logic early;
    chk({tag, "_start_ready"}, 32'(sif.start_ready), 32'd1);
    sif.a_in        = a;
    sif.b_in        = b;
    sif.start_valid = 1'b1;
    step();
    sif.start_valid = 1'b0;
    sif.a_in        = 8'hA5;
    sif.b_in        = 8'h5A;
    early = 1'b0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (sif.done_valid || sif.start_ready) early = 1'b1;
      step();
    end
    if (sif.done_valid) early = 1'b1;
    chk({tag, "_busy_no_early_done"}, 32'(early), 32'd0);
    step();
    chk({tag, "_done_valid"}, 32'(sif.done_valid), 32'd1);
    chk({tag, "_diff"}, 32'(sif.diff_out), 32'(exp_d));
    chk({tag, "_borrow"}, 32'(sif.borrow_out), 32'(exp_br));
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    chk({tag, "_zero"}, 32'(sif.zero_out), 32'(exp_z));
`else
    early = exp_z;
`endif
    sif.done_ready = 1'b1;
    step();
    sif.done_ready = 1'b0;
    chk({tag, "_idle_after_accept"}, {30'd0, sif.start_ready, sif.done_valid}, 32'b10);
  endtask

  initial begin
    logic stable;
    errors          = 0;
    checks          = 0;
    rst_n           = 1'b0;
    sif.start_valid = 1'b0;
    sif.done_ready  = 1'b0;
    sif.a_in        = '0;
    sif.b_in        = '0;

    // Reset state
    step();
    chk("rst_start_ready", 32'(sif.start_ready), 32'd1);
    chk("rst_done_valid", 32'(sif.done_valid), 32'd0);
    chk("rst_diff", 32'(sif.diff_out), 32'd0);
    chk("rst_borrow", 32'(sif.borrow_out), 32'd0);
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    chk("rst_zero", 32'(sif.zero_out), 32'd0);
`endif
    rst_n = 1'b1;
    step();

    // Directed operations
    run_op("sub_05_03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    run_op("sub_03_05", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    run_op("sub_FF_01", 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0);
    run_op("sub_00_00", 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    run_op("sub_80_7F", 8'h80, 8'h7F, 8'h01, 1'b0, 1'b0);

    // Backpressure: result held for 5 cycles while done_ready stays low
    sif.a_in        = 8'h3C;
    sif.b_in        = 8'h4D;
    sif.start_valid = 1'b1;
    step();
    sif.start_valid = 1'b0;
    for (int i = 0; i < WIDTH; i++) step();
    chk("bp_done_valid", 32'(sif.done_valid), 32'd1);
    chk("bp_diff", 32'(sif.diff_out), 32'hEF);
    chk("bp_borrow", 32'(sif.borrow_out), 32'd1);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sif.start_valid = 1'b1;
      step();
      if (sif.done_valid !== 1'b1 || sif.start_ready !== 1'b0 ||
          sif.diff_out !== 8'hEF || sif.borrow_out !== 1'b1) stable = 1'b0;
    end
    sif.start_valid = 1'b0;
    chk("bp_held_stable", 32'(stable), 32'd1);
    sif.done_ready = 1'b1;
    step();
    sif.done_ready = 1'b0;
    chk("bp_idle_after_accept", {30'd0, sif.start_ready, sif.done_valid}, 32'b10);

    // Back-to-back: start_valid held high across the accept edge
    sif.a_in        = 8'h20;
    sif.b_in        = 8'h0A;
    sif.start_valid = 1'b1;
    step();
    sif.a_in = 8'h0A;
    sif.b_in = 8'h20;
    for (int i = 0; i < WIDTH; i++) step();
    chk("b2b1_done_valid", 32'(sif.done_valid), 32'd1);
    chk("b2b1_diff", 32'(sif.diff_out), 32'h16);
    chk("b2b1_borrow", 32'(sif.borrow_out), 32'd0);
    sif.done_ready = 1'b1;
    step();
    sif.done_ready = 1'b0;
    chk("b2b_idle_gap", {30'd0, sif.start_ready, sif.done_valid}, 32'b10);
    step();
    sif.start_valid = 1'b0;
    chk("b2b2_accepted", 32'(sif.start_ready), 32'd0);
    for (int i = 0; i < WIDTH; i++) step();
    chk("b2b2_done_valid", 32'(sif.done_valid), 32'd1);
    chk("b2b2_diff", 32'(sif.diff_out), 32'hEA);
    chk("b2b2_borrow", 32'(sif.borrow_out), 32'd1);
    sif.done_ready = 1'b1;
    step();
    sif.done_ready = 1'b0;

    // Asynchronous reset in the middle of RUN
    sif.a_in        = 8'h55;
    sif.b_in        = 8'h11;
    sif.start_valid = 1'b1;
    step();
    sif.start_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_done_valid", 32'(sif.done_valid), 32'd0);
    chk("midrst_start_ready", 32'(sif.start_ready), 32'd1);
    chk("midrst_diff", 32'(sif.diff_out), 32'd0);
    step();
    rst_n = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < WIDTH + 2; i++) begin
      step();
      if (sif.done_valid !== 1'b0) stable = 1'b0;
    end
    chk("midrst_no_done_pulse", 32'(stable), 32'd1);
    run_op("sub_10_01", 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_serial_subtractor
`default_nettype wire
